// File: rtl/serial_tx_sequencer.sv
// serial_tx_sequencer: pops 9-bit words from the transmit FIFO and frames them as async serial characters.
// Optional line-break state (control[6]) is built only when SERIAL_TX_BREAK_EN is defined.
module serial_tx_sequencer #(
    parameter int BRD_FRAC_BITS = 8,
    parameter int MIN_BRD_INT   = 2
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic [31:0] control,
    input  logic [31:0] brd,
    input  logic        fifo_empty,
    input  logic [8:0]  fifo_rd_data,
    output logic        fifo_rd_request,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);
    localparam int FW = BRD_FRAC_BITS;
    localparam int IW = 32 - BRD_FRAC_BITS;
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cfg_q, cfg_d;
    logic [31:0]   brd_q, brd_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_bit_q, par_bit_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [FW-1:0] frac_acc_q, frac_acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
`ifdef SERIAL_TX_BREAK_EN
    logic          brk_hold_q, brk_hold_d;
`endif

    logic          brd_legal;
    logic          bit_entry;
    logic          bit_last;
    logic          par_en;
    logic [FW:0]   frac_sum;
    logic [CW-1:0] bit_len;
    logic [2:0]    last_idx;
    logic [7:0]    size_mask;
    logic          unused_bits;

    // cfg_q holds control[5:1]: [1:0] size, [3:2] parity, [4] two stop bits
    assign brd_legal = (brd[31:FW] >= IW'(MIN_BRD_INT));
    assign frac_sum  = {1'b0, frac_acc_q} + {1'b0, brd_q[FW-1:0]};
    assign bit_len   = {1'b0, brd_q[31:FW]} + CW'(frac_sum[FW]);
    assign bit_last  = (cnt_q == CW'(1));
    assign last_idx  = 3'd4 + {1'b0, cfg_q[1:0]};
    assign size_mask = 8'hFF >> (2'd3 - cfg_q[1:0]);
    assign par_en    = cfg_q[3] ^ cfg_q[2];

    assign unused_bits = ^{control[31:6], fifo_rd_data[8]};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= S_IDLE;
            cfg_q        <= '0;
            brd_q        <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            frac_acc_q   <= '0;
            cnt_q        <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SERIAL_TX_BREAK_EN
            brk_hold_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            brd_q        <= brd_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            frac_acc_q   <= frac_acc_d;
            cnt_q        <= cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef SERIAL_TX_BREAK_EN
            brk_hold_q   <= brk_hold_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        brd_d        = brd_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        frac_acc_d   = frac_acc_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        bit_entry    = 1'b0;
`ifdef SERIAL_TX_BREAK_EN
        brk_hold_d   = brk_hold_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef SERIAL_TX_BREAK_EN
                if (control[6] && brd_legal) begin
                    state_d    = S_BREAK;
                    brd_d      = brd;
                    frac_acc_d = '0;
                    brk_hold_d = 1'b1;
                end else
`endif
                if (control[0] && !fifo_empty && brd_legal) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                // Framing and timing are frozen here for the whole character
                cfg_d      = control[5:1];
                brd_d      = brd;
                frac_acc_d = '0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                shift_d    = fifo_rd_data[7:0];
                par_bit_d  = (^(fifo_rd_data[7:0] & size_mask)) ^ (cfg_q[3:2] == 2'b10);
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                bit_entry  = 1'b1;
                state_d    = S_START;
            end
            S_START: begin
                if (bit_last) begin
                    bit_entry = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    bit_entry = 1'b1;
                    if (bit_idx_q == last_idx) begin
                        state_d = par_en ? S_PARITY : S_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_last) begin
                    bit_entry = 1'b1;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_last) begin
                    if (cfg_q[4] && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        bit_entry  = 1'b1;
                    end else begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_BREAK_EN
            S_BREAK: begin
                // Hold low while requested, then one idle-high bit period before IDLE
                if (brk_hold_q) begin
                    if (!control[6]) begin
                        brk_hold_d = 1'b0;
                        bit_entry  = 1'b1;
                    end
                end else if (bit_last) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (bit_entry) begin
            frac_acc_d = frac_sum[FW-1:0];
            cnt_d      = bit_len;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end

        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
`ifdef SERIAL_TX_BREAK_EN
            S_BREAK:  tx_d = !brk_hold_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign fifo_rd_request = (state_q == S_POP);
    assign tx              = tx_q;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Scoreboard bench for serial_tx_sequencer: words pushed into a FIFO model, frames decoded from tx.
// Break checks follow SERIAL_TX_BREAK_EN.
module tb_serial_tx_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] control = '0;
    logic [31:0] brd = '0;
    logic        fifo_empty = 1'b1;
    logic [8:0]  fifo_rd_data = '0;
    logic        fifo_rd_request;
    logic        tx;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    serial_tx_sequencer dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .control        (control),
        .brd            (brd),
        .fifo_empty     (fifo_empty),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_request(fifo_rd_request),
        .tx             (tx),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    typedef struct {
        logic [8:0]  word;
        logic [31:0] ctrl;
        logic [31:0] brd;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] fifo_mem[$];
    logic       push_en = 1'b0;
    logic [8:0] push_data = '0;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  pop_cnt = 0;
    int  last_pop_cyc = -100;
    int  prev_done_cyc = -1;
    int  frames_seen = 0;
    bit  mon_en = 1'b1;
    bit  check_gap = 1'b0;
    logic prev_req = 1'b0;

    task automatic check(input string tag, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: read data valid the cycle after the pop strobe
    always @(posedge clk) begin
        if (push_en) fifo_mem.push_back(push_data);
        if (fifo_rd_request && fifo_mem.size() > 0) fifo_rd_data <= fifo_mem.pop_front();
        fifo_empty <= (fifo_mem.size() == 0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_request) begin
                check("pop_when_empty", fifo_empty, 0);
                check("pop_back_to_back", prev_req, 0);
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            prev_req = fifo_rd_request;
        end
    end

    initial begin : frame_mon
        exp_t e;
        logic vals[12];
        int   nb, nbits, acc, len, cnt, n;
        logic p;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx == 1'b0) begin
                check("start_latency", cyc - last_pop_cyc, 2);
                if (check_gap && prev_done_cyc >= 0) check("frame_gap", cyc - prev_done_cyc, 3);
                check("busy_in_frame", busy, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", exp_q.size(), 1);
                    n = 0;
                    while (busy && n < 2000) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    e = exp_q.pop_front();
                    nbits = 5 + int'(e.ctrl[2:1]);
                    nb = 0;
                    vals[nb++] = 1'b0;
                    p = 1'b0;
                    for (int i = 0; i < nbits; i++) begin
                        vals[nb++] = e.word[i];
                        p = p ^ e.word[i];
                    end
                    if (e.ctrl[4:3] == 2'b01) vals[nb++] = p;
                    if (e.ctrl[4:3] == 2'b10) vals[nb++] = ~p;
                    vals[nb++] = 1'b1;
                    if (e.ctrl[5]) vals[nb++] = 1'b1;
                    acc = 0;
                    for (int k = 0; k < nb; k++) begin
                        acc = acc + int'(e.brd[7:0]);
                        len = int'(e.brd[31:8]) + (acc >> 8);
                        acc = acc & 255;
                        cnt = 0;
                        repeat (len) begin
                            if (tx === vals[k]) cnt++;
                            @(negedge clk);
                        end
                        check($sformatf("bit%0d_w%03h", k, e.word), cnt, len);
                    end
                    check("frame_done", frame_done, 1);
                    check("busy_after_frame", busy, 0);
                    prev_done_cyc = cyc;
                    frames_seen++;
                    $display("frame word=%03h ctrl=%02h brd=%08h bits=%0d", e.word, e.ctrl[7:0], e.brd, nb);
                end
            end
        end
    end

    task automatic push_word(input logic [8:0] w, input bit expect_it);
        @(negedge clk);
        push_en = 1'b1;
        push_data = w;
        if (expect_it) exp_q.push_back('{w, control, brd});
        @(posedge clk);
        #1 push_en = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            check("drain_timeout", n, 0);
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tx_low(input int budget);
        int n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("tx_low_timeout", n, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pc0, f0, lo, bz;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_pop", fifo_rd_request, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 at 10 clocks per bit
        brd = 32'h0000_0A00;
        control = 32'h7;
        pc0 = pop_cnt;
        push_word(9'h055, 1'b1);
        wait_done(400);
        check("t1_pops", pop_cnt - pc0, 1);

        // Parity, sizes and stop bits
        control = 32'h0D;
        push_word(9'h041, 1'b1);
        wait_done(400);
        control = 32'h15;
        push_word(9'h041, 1'b1);
        wait_done(400);
        control = 32'h21;
        push_word(9'h116, 1'b1);
        wait_done(400);
        control = 32'h33;
        push_word(9'h1FF, 1'b1);
        wait_done(400);

        // Fractional divisor 10.5
        brd = 32'h0000_0A80;
        control = 32'h7;
        push_word(9'h0C3, 1'b1);
        wait_done(400);
        check("t3_frac_acc", dut.frac_acc_q, 0);

        // Break request held 50 cycles in IDLE
        brd = 32'h0000_0A00;
        mon_en = 1'b0;
        pc0 = pop_cnt;
        lo = 0;
        bz = 0;
        @(posedge clk);
        #1 control = 32'h40;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lo++;
            if (busy) bz++;
        end
        @(posedge clk);
        #1 control = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lo++;
            if (busy) bz++;
        end
`ifdef SERIAL_TX_BREAK_EN
        check("brk_tx_low_cycles", lo, 50);
        check("brk_busy_cycles", bz, 60);
`else
        check("brk_tx_low_cycles", lo, 0);
        check("brk_busy_cycles", bz, 0);
`endif
        check("brk_pops", pop_cnt - pc0, 0);
        check("brk_tx_idle", tx, 1);
        mon_en = 1'b1;

        // Empty FIFO then three back-to-back frames
        control = 32'h7;
        pc0 = pop_cnt;
        repeat (20) @(negedge clk);
        check("t4_no_pop_empty", pop_cnt - pc0, 0);
        check("t4_tx_idle", tx, 1);
        prev_done_cyc = -1;
        check_gap = 1'b1;
        f0 = frames_seen;
        push_word(9'h0A5, 1'b1);
        push_word(9'h03C, 1'b1);
        push_word(9'h1E1, 1'b1);
        wait_done(900);
        check_gap = 1'b0;
        check("t4_pops", pop_cnt - pc0, 3);
        check("t4_frames", frames_seen - f0, 3);
        pc0 = pop_cnt;
        lo = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx == 1'b0) lo++;
        end
        check("t4_idle_pops", pop_cnt - pc0, 0);
        check("t4_idle_tx_low", lo, 0);

        // Reset asserted mid-frame forces the line high at once
        mon_en = 1'b0;
        push_word(9'h0F0, 1'b0);
        wait_tx_low(100);
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        control = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_tx_after", tx, 1);
        mon_en = 1'b1;

        // Enable dropped mid-DATA with two words still queued
        control = 32'h6;
        pc0 = pop_cnt;
        push_word(9'h0B2, 1'b1);
        push_word(9'h011, 1'b0);
        push_word(9'h022, 1'b0);
        control = 32'h7;
        wait_tx_low(50);
        repeat (30) @(negedge clk);
        control = 32'h6;
        wait_done(400);
        repeat (40) @(negedge clk);
        check("t5_pops", pop_cnt - pc0, 1);
        check("t5_fifo_left", fifo_mem.size(), 2);

        // Illegal divisor keeps the sequencer idle
        brd = 32'h0000_0100;
        control = 32'h7;
        pc0 = pop_cnt;
        lo = 0;
        bz = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx == 1'b0) lo++;
            if (busy) bz++;
        end
        check("t5_illegal_brd_pops", pop_cnt - pc0, 0);
        check("t5_illegal_brd_tx_low", lo, 0);
        check("t5_illegal_brd_busy", bz, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
